// File: rtl/decode_pipe_stage.sv
// Registered RV32I/RV64I decode stage with valid/ready on both sides and a one-entry skid register.
// Optional performance counters are enabled by defining DECODE_PERF_CNT_EN.
module decode_pipe_stage #(
  parameter int XLEN  = 32,
  parameter int PC_W  = 32,
  parameter int CNT_W = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [PC_W-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [PC_W-1:0] out_pc,
  output logic [6:0]      out_opcode,
  output logic [2:0]      out_funct3,
  output logic [6:0]      out_funct7,
  output logic [4:0]      out_rd,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [XLEN-1:0] out_imm,
  output logic            out_illegal
`ifdef DECODE_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] perf_decoded,
  output logic [CNT_W-1:0] perf_stall,
  output logic [CNT_W-1:0] perf_illegal
`endif
);

  localparam bit RV64 = (XLEN == 64);

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_MISC   = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_IMM32  = 7'b0011011;
  localparam logic [6:0] OP_REG32  = 7'b0111011;

  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [XLEN-1:0] imm;
    logic            illegal;
  } bundle_t;

  bundle_t     dec, out_q, skid_q;
  logic        out_valid_q, skid_valid_q;
  logic [4:0]  dec_rd, dec_rs1, dec_rs2;
  logic        dec_ill;
  logic [31:0] imm32;
  logic [XLEN-1:0] imm_x;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

  assign imm_i = {{20{in_instr[31]}}, in_instr[31:20]};
  assign imm_s = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
  assign imm_b = {{19{in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25],
                  in_instr[11:8], 1'b0};
  assign imm_u = {in_instr[31:12], 12'b0};
  assign imm_j = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12], in_instr[20],
                  in_instr[30:21], 1'b0};

  always_comb begin
    dec_rd  = in_instr[11:7];
    dec_rs1 = in_instr[19:15];
    dec_rs2 = 5'd0;
    dec_ill = 1'b0;
    imm32   = 32'd0;
    case (in_instr[6:0])
      OP_LUI, OP_AUIPC: begin
        imm32   = imm_u;
        dec_rs1 = 5'd0;
      end
      OP_JAL: begin
        imm32   = imm_j;
        dec_rs1 = 5'd0;
      end
      OP_JALR: begin
        imm32   = imm_i;
        dec_ill = (in_instr[14:12] != 3'b000);
      end
      OP_LOAD, OP_IMM: imm32 = imm_i;
      OP_BRANCH: begin
        imm32   = imm_b;
        dec_rd  = 5'd0;
        dec_rs2 = in_instr[24:20];
        dec_ill = (in_instr[14:13] == 2'b01);
      end
      OP_STORE: begin
        imm32   = imm_s;
        dec_rd  = 5'd0;
        dec_rs2 = in_instr[24:20];
      end
      OP_REG: dec_rs2 = in_instr[24:20];
      OP_MISC, OP_SYSTEM: imm32 = 32'd0;
      OP_IMM32: begin
        if (RV64) imm32 = imm_i;
        else dec_ill = 1'b1;
      end
      OP_REG32: begin
        if (RV64) dec_rs2 = in_instr[24:20];
        else dec_ill = 1'b1;
      end
      // Anything else, including words whose low two bits are not 11.
      default: dec_ill = 1'b1;
    endcase
  end

  // Every format's 32-bit immediate is already sign-extended, so widening is uniform.
  generate
    if (RV64) begin : g_imm64
      assign imm_x = {{32{imm32[31]}}, imm32};
    end else begin : g_imm32
      assign imm_x = imm32;
    end
  endgenerate

  assign dec = {in_pc, in_instr[6:0], in_instr[14:12], in_instr[31:25],
                dec_rd, dec_rs1, dec_rs2, imm_x, dec_ill};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q        <= '0;
      skid_q       <= '0;
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
    end else if (flush) begin
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
    end else if (out_valid_q && !out_ready) begin
      if (in_valid && !skid_valid_q) begin
        skid_q       <= dec;
        skid_valid_q <= 1'b1;
      end
    end else if (skid_valid_q) begin
      out_q        <= skid_q;
      out_valid_q  <= 1'b1;
      skid_valid_q <= 1'b0;
    end else if (in_valid) begin
      out_q       <= dec;
      out_valid_q <= 1'b1;
    end else begin
      out_valid_q <= 1'b0;
    end
  end

  assign in_ready    = !skid_valid_q;
  assign out_valid   = out_valid_q;
  assign out_pc      = out_q.pc;
  assign out_opcode  = out_q.opcode;
  assign out_funct3  = out_q.funct3;
  assign out_funct7  = out_q.funct7;
  assign out_rd      = out_q.rd;
  assign out_rs1     = out_q.rs1;
  assign out_rs2     = out_q.rs2;
  assign out_imm     = out_q.imm;
  assign out_illegal = out_q.illegal;

`ifdef DECODE_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_decoded <= '0;
      perf_stall   <= '0;
      perf_illegal <= '0;
    end else begin
      if (out_valid_q && out_ready) perf_decoded <= perf_decoded + 1'b1;
      if (out_valid_q && !out_ready) perf_stall <= perf_stall + 1'b1;
      if (out_valid_q && out_ready && out_q.illegal) perf_illegal <= perf_illegal + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_decode_pipe_stage.sv
// Bench for decode_pipe_stage: a two-deep FIFO model with decode rules, random traffic and directed cases.
module tb_decode_pipe_stage;
  localparam int XLEN  = 32;
  localparam int PC_W  = 32;
  localparam int CNT_W = 32;
  localparam int BW    = PC_W + 7 + 3 + 7 + 15 + XLEN + 1;

  logic            clk, rst_n, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0]     in_instr;
  logic [PC_W-1:0] in_pc, out_pc;
  logic [6:0]      out_opcode, out_funct7;
  logic [2:0]      out_funct3;
  logic [4:0]      out_rd, out_rs1, out_rs2;
  logic [XLEN-1:0] out_imm;
  logic            out_illegal;
`ifdef DECODE_PERF_CNT_EN
  logic [CNT_W-1:0] perf_decoded, perf_stall, perf_illegal;
`endif

  decode_pipe_stage #(.XLEN(XLEN), .PC_W(PC_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_opcode(out_opcode), .out_funct3(out_funct3), .out_funct7(out_funct7),
    .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2),
    .out_imm(out_imm), .out_illegal(out_illegal)
`ifdef DECODE_PERF_CNT_EN
    , .perf_decoded(perf_decoded), .perf_stall(perf_stall), .perf_illegal(perf_illegal)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic longint sext(input longint v, input int n);
    return (v <<< (64 - n)) >>> (64 - n);
  endfunction

  // Decode rules written straight from the instruction-format table.
  function automatic logic [BW-1:0] model_bundle(input logic [31:0] i, input logic [PC_W-1:0] pc);
    longint imm;
    logic [4:0] rd, rs1, rs2;
    bit ill;
    bit rv64;
    rv64 = (XLEN == 64);
    imm = 0; rd = i[11:7]; rs1 = i[19:15]; rs2 = 5'd0; ill = 1'b0;
    case (i[6:0])
      7'h37, 7'h17: begin imm = sext({i[31:12], 12'b0}, 32); rs1 = 0; end
      7'h6f: begin imm = sext({i[31], i[19:12], i[20], i[30:21], 1'b0}, 21); rs1 = 0; end
      7'h67: begin imm = sext(i[31:20], 12); ill = (i[14:12] != 0); end
      7'h03, 7'h13: imm = sext(i[31:20], 12);
      7'h63: begin
        imm = sext({i[31], i[7], i[30:25], i[11:8], 1'b0}, 13);
        rd = 0; rs2 = i[24:20]; ill = (i[14:12] == 3'd2) || (i[14:12] == 3'd3);
      end
      7'h23: begin imm = sext({i[31:25], i[11:7]}, 12); rd = 0; rs2 = i[24:20]; end
      7'h33: rs2 = i[24:20];
      7'h0f, 7'h73: imm = 0;
      7'h1b: if (rv64) imm = sext(i[31:20], 12); else ill = 1'b1;
      7'h3b: if (rv64) rs2 = i[24:20]; else ill = 1'b1;
      default: ill = 1'b1;
    endcase
    return {pc, i[6:0], i[14:12], i[31:25], rd, rs1, rs2, imm[XLEN-1:0], ill};
  endfunction

  typedef struct { logic [31:0] instr; logic [PC_W-1:0] pc; } item_t;
  item_t q[$];
  int unsigned m_dec, m_stall, m_ill;

  // The stage behaves as a FIFO of depth two whose head is the output register.
  task automatic model_step();
    bit pop, push;
    item_t it;
    if (!rst_n) begin
      q.delete(); m_dec = 0; m_stall = 0; m_ill = 0;
    end else begin
      pop  = (q.size() > 0) && out_ready;
      push = in_valid && (q.size() < 2) && !flush;
      if (q.size() > 0 && !out_ready) m_stall++;
      if (pop) begin
        m_dec++;
        if (model_bundle(q[0].instr, q[0].pc) & 1) m_ill++;
      end
      if (flush) q.delete();
      else begin
        if (pop) void'(q.pop_front());
        if (push) begin it.instr = in_instr; it.pc = in_pc; q.push_back(it); end
      end
    end
  endtask

  initial forever begin
    @(posedge clk or negedge rst_n);
    model_step();
  end

  logic [BW-1:0] dut_bundle;
  assign dut_bundle = {out_pc, out_opcode, out_funct3, out_funct7, out_rd, out_rs1, out_rs2,
                       out_imm, out_illegal};

  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      chk("in_ready", in_ready, q.size() < 2);
      chk("out_valid", out_valid, q.size() > 0);
      if (q.size() > 0) chk("bundle", dut_bundle, model_bundle(q[0].instr, q[0].pc));
`ifdef DECODE_PERF_CNT_EN
      chk("perf_decoded", perf_decoded, m_dec[CNT_W-1:0]);
      chk("perf_stall", perf_stall, m_stall[CNT_W-1:0]);
      chk("perf_illegal", perf_illegal, m_ill[CNT_W-1:0]);
`endif
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic send1(input logic [31:0] w, input logic [PC_W-1:0] pc);
    in_valid = 1'b1; in_instr = w; in_pc = pc;
    step();
    in_valid = 1'b0;
  endtask

  logic [6:0] ops [13] = '{7'h37, 7'h17, 7'h6f, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33,
                           7'h0f, 7'h73, 7'h1b, 7'h3b};

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    w = $urandom;
    if ($urandom_range(0, 7) != 0) w[6:0] = ops[$urandom_range(0, 12)];
    return w;
  endfunction

  logic [31:0] bp_w [4] = '{32'h00500093, 32'h0020A423, 32'hFE000EE3, 32'h00000000};
  int guard;
`ifdef DECODE_PERF_CNT_EN
  logic [CNT_W-1:0] d0, s0, i0;
`endif

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_instr = '0; in_pc = '0;
    #3;
    chk("reset_out_valid", out_valid, 0);
    chk("reset_in_ready", in_ready, 1);
    chk("reset_payload", dut_bundle, 0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    step();

    // ADDI x1, x0, 5
    out_ready = 1'b1;
    send1(32'h00500093, 32'h100);
    chk("addi_valid", out_valid, 1);
    chk("addi_opcode", out_opcode, 7'h13);
    chk("addi_rd", out_rd, 1);
    chk("addi_rs1", out_rs1, 0);
    chk("addi_imm", out_imm, 5);
    chk("addi_illegal", out_illegal, 0);

    // SW then BEQ back-to-back
    in_valid = 1'b1; in_instr = 32'h0020A423; in_pc = 32'h104;
    step();
    chk("sw_rs1", out_rs1, 1);
    chk("sw_rs2", out_rs2, 2);
    chk("sw_rd", out_rd, 0);
    chk("sw_imm", out_imm, 8);
    in_instr = 32'hFE000EE3; in_pc = 32'h108;
    step();
    in_valid = 1'b0;
    chk("beq_valid", out_valid, 1);
    chk("beq_pc", out_pc, 32'h108);
    chk("beq_imm", out_imm, {{(XLEN-4){1'b1}}, 4'hC});

    send1(32'h123452B7, 32'h10C);
    chk("lui_rd", out_rd, 5);
    chk("lui_imm", out_imm, 32'h12345000);
    send1(32'h00000000, 32'h110);
    chk("zero_illegal", out_illegal, 1);
    send1(32'h00001067, 32'h114);
    chk("jalr_f3_illegal", out_illegal, 1);
    step();

    // Backpressure: four words, output stalled for three cycles
`ifdef DECODE_PERF_CNT_EN
    d0 = perf_decoded; s0 = perf_stall; i0 = perf_illegal;
`endif
    out_ready = 1'b0; in_valid = 1'b1; in_instr = bp_w[0]; in_pc = 32'h200;
    step();
    chk("bp_ready_after_1", in_ready, 1);
    in_instr = bp_w[1]; in_pc = 32'h204;
    step();
    chk("bp_ready_after_2", in_ready, 0);
    in_instr = bp_w[2]; in_pc = 32'h208;
    step();
    chk("bp_stable_pc", out_pc, 32'h200);
    step();
    chk("bp_stable_pc2", out_pc, 32'h200);
    chk("bp_stable_imm", out_imm, 5);
    out_ready = 1'b1;
    for (int k = 2; k < 4; k++) begin
      in_instr = bp_w[k]; in_pc = 32'h200 + PC_W'(4 * k);
      guard = 0;
      while (!in_ready && guard < 20) begin step(); guard++; end
      chk("bp_accept_wait", guard < 20, 1);
      step();
    end
    in_valid = 1'b0;
    chk("bp_last_pc", out_pc, 32'h20C);
    step();
    chk("bp_drained", out_valid, 0);
`ifdef DECODE_PERF_CNT_EN
    chk("bp_decoded_delta", perf_decoded - d0, 4);
    chk("bp_stall_delta", perf_stall - s0, 3);
    chk("bp_illegal_delta", perf_illegal - i0, 1);
`endif

    // Flush with both entries full and a word offered
    out_ready = 1'b0; in_valid = 1'b1; in_instr = 32'h00100113; in_pc = 32'h300;
    step();
    in_pc = 32'h304;
    step();
    flush = 1'b1; in_pc = 32'h308;
    step();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_out_valid", out_valid, 0);
    chk("flush_in_ready", in_ready, 1);
    out_ready = 1'b1;
    send1(32'h00200193, 32'h500);
    chk("post_flush_valid", out_valid, 1);
    chk("post_flush_pc", out_pc, 32'h500);

    // Random traffic with an asynchronous reset in the middle
    for (int n = 0; n < 3000; n++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 49) == 0);
      in_instr  = rand_instr();
      in_pc     = $urandom;
      if (n == 1500) begin
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset_valid", out_valid, 0);
        chk("async_reset_ready", in_ready, 1);
        step();
        rst_n = 1'b1;
      end
      step();
    end
    in_valid = 1'b0; flush = 1'b0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/decode_pipe_stage.md
Name: decode_pipe_stage

Overview:
- Registered, parametrised RV32I/RV64I decode stage with valid/ready handshakes on both sides.
- Sits between fetch and execute. Accepts a 32-bit instruction word plus its PC, and emits decoded fields, a sign-extended immediate and an illegal-instruction flag one cycle later.
- A 2-entry skid buffer gives full throughput under backpressure. A flush input discards in-flight entries.

Parameters:
- XLEN, 32, datapath width (32 or 64). Sets the immediate width and enables RV64 opcodes.
- PC_W, 32, width of the PC passthrough.
- CNT_W, 32, width of the performance counters (optional feature only).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  discard all held entries
- in_valid  in  1  upstream word valid
- in_ready  out  1  stage can accept a word
- in_instr  in  32  instruction word
- in_pc  in  PC_W  instruction PC
- out_valid  out  1  decoded bundle valid
- out_ready  in  1  downstream accepts
- out_pc  out  PC_W  PC of the decoded instruction
- out_opcode  out  7  instr[6:0]
- out_funct3  out  3  instr[14:12]
- out_funct7  out  7  instr[31:25]
- out_rd  out  5  instr[11:7]; 0 for S/B types
- out_rs1  out  5  instr[19:15]; 0 for U/J types
- out_rs2  out  5  instr[24:20]; 0 unless R/S/B type
- out_imm  out  XLEN  sign-extended immediate
- out_illegal  out  1  unsupported encoding

Behaviour:
- Reset (rst_n=0, asynchronous): out_valid=0, skid entry empty, all out_* payload registers 0. in_ready=1 during reset and after release.
- Decode is combinational on the input word and is registered on accept.
- Latency: a word accepted in cycle N is presented with out_valid=1 in cycle N+1 when the output register is free.
- Handshakes:
  - Transfer happens on valid&&ready.
  - in_ready = !skid_valid; it is registered state, with no combinational path from out_ready.
  - The payload is stable while out_valid&&!out_ready.
  - When the output is stalled and a word arrives, the word goes into the skid entry.
  - When the output drains, the skid entry moves into the output register next cycle.
  - Order is always preserved.
- Simultaneous output drain and input accept with the skid entry empty: the output register loads the new word; out_valid stays 1.
- flush has priority over everything else:
  - Next cycle: out_valid=0 and the skid entry is empty.
  - A word offered in the flush cycle is dropped.
  - Payload registers need not clear.
- Immediate by format, sign bit instr[31] extended to XLEN:
  - I: instr[31:20].
  - S: {instr[31:25],instr[11:7]}.
  - B: {instr[31],instr[7],instr[30:25],instr[11:8],0}.
  - U: {instr[31:12],12'b0}, sign-extended when XLEN=64.
  - J: {instr[31],instr[19:12],instr[20],instr[30:21],0}.
  - R, MISC-MEM, SYSTEM: 0.
- Legal opcodes: 0110111, 0010111, 1101111, 1100111, 1100011, 0000011, 0100011, 0010011, 0110011, 0001111, 1110011. When XLEN=64, 0011011 and 0111011 are also legal.
- out_illegal=1 in any of these cases:
  - instr[1:0]!=2'b11.
  - The opcode is not in the legal set.
  - JALR with funct3!=0.
  - BRANCH with funct3 of 010 or 011.
- An illegal word still flows through the stage normally; only the flag is set.

Optional Feature:
- Macro: DECODE_PERF_CNT_EN.
- Defined:
  - Extra outputs perf_decoded (CNT_W): count of output transfers.
  - perf_stall (CNT_W): cycles with out_valid&&!out_ready.
  - perf_illegal (CNT_W): output transfers with out_illegal=1.
  - All counters reset to 0, wrap modulo 2^CNT_W, and are not affected by flush.
- Undefined: these ports and the counter logic are absent; behaviour is otherwise identical.

Test Plan:
- ADDI: in 0x00500093, out_ready=1 -> next cycle out_valid=1, opcode=0x13, rd=1, rs1=0, imm=5, illegal=0.
- SW then BEQ back-to-back:
  - 0x0020A423 -> rs1=1, rs2=2, rd=0, imm=8.
  - 0xFE000EE3 -> imm=0xFFFFFFFC (XLEN=32) or 0xFFFFFFFFFFFFFFFC (XLEN=64).
  - Both appear on consecutive cycles.
- LUI 0x123452B7 -> rd=5, imm=0x12345000. Word 0x00000000 -> illegal=1. JALR with funct3=1 -> illegal=1.
- Backpressure: stream 4 words with out_ready=0 for 3 cycles -> in_ready falls after 2 accepted; after release all 4 emerge in order with no loss or duplication; payload stable while stalled.
- Flush with both entries full and in_valid=1 -> next cycle out_valid=0, in_ready=1; the next accepted word is the first output.
- Async reset asserted mid-stream, between clock edges -> out_valid=0 immediately.
- Counters (with DECODE_PERF_CNT_EN): decoded=4, stall=3, illegal matches the count of illegal words sent.
